// File: rtl/cpu_run_ctrl.sv
// Run/halt sequencer for the single-cycle RV32 core: produces the commit enable that
// gates PC, register-file and data-RAM writes, with start/stop/step, breakpoint and retire count.
module cpu_run_ctrl #(
  parameter int PC_W  = 11,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             step,
  input  logic [PC_W-1:0]  pc,
  input  logic [6:0]       opcode,
  input  logic             bp_en,
  input  logic [PC_W-1:0]  bp_addr,
  output logic             commit_en,
  output logic [1:0]       state,
  output logic [1:0]       halt_cause,
  output logic [CNT_W-1:0] retired,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2,
    HALT = 2'd3
  } state_t;

  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0] CAUSE_STOP    = 2'd2;
  localparam logic [1:0] CAUSE_BP      = 2'd3;

  state_t     cur_state;
  state_t     nxt_state;
  logic [1:0] cause_nxt;
  logic       skip_bp;
  logic       skip_nxt;
  logic       legal;
  logic       bp_hit;

  function automatic logic is_legal(input logic [6:0] op);
    case (op)
      7'b0110011, 7'b0010011, 7'b0100011, 7'b0000011,
      7'b1100011, 7'b1101111, 7'b1100111: is_legal = 1'b1;
      default:                            is_legal = 1'b0;
    endcase
  endfunction

  assign legal  = is_legal(opcode);
  // skip_bp lets the instruction that tripped the breakpoint commit once on resume
  assign bp_hit = bp_en & (pc == bp_addr) & ~skip_bp;
  assign state  = cur_state;
  assign busy   = (cur_state == RUN) | (cur_state == STEP);

  always_comb begin
    commit_en = 1'b0;
    case (cur_state)
      RUN:     commit_en = ~stop & legal & ~bp_hit;
      STEP:    commit_en = ~stop & legal;
      default: commit_en = 1'b0;
    endcase
  end

  always_comb begin
    nxt_state = cur_state;
    cause_nxt = halt_cause;
    skip_nxt  = skip_bp & ~commit_en;
    case (cur_state)
      IDLE, HALT: begin
        if (start || step) begin
          nxt_state = start ? RUN : STEP;
          cause_nxt = CAUSE_NONE;
          if (cur_state == HALT && halt_cause == CAUSE_BP)
            skip_nxt = 1'b1;
        end
      end
      RUN: begin
        if (stop) begin
          nxt_state = HALT;
          cause_nxt = CAUSE_STOP;
        end else if (!legal) begin
          nxt_state = HALT;
          cause_nxt = CAUSE_ILLEGAL;
        end else if (bp_hit) begin
          nxt_state = HALT;
          cause_nxt = CAUSE_BP;
        end
      end
      STEP: begin
        nxt_state = HALT;
        if (stop)
          cause_nxt = CAUSE_STOP;
        else if (!legal)
          cause_nxt = CAUSE_ILLEGAL;
        else
          cause_nxt = CAUSE_NONE;
      end
      default: nxt_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_state  <= IDLE;
      halt_cause <= CAUSE_NONE;
      skip_bp    <= 1'b0;
      retired    <= '0;
    end else begin
      cur_state  <= nxt_state;
      halt_cause <= cause_nxt;
      skip_bp    <= skip_nxt;
      if (commit_en)
        retired <= retired + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl: a 32-bit-counter instance and a 4-bit-counter
// instance share all stimulus; the narrow one exercises counter wrap.
module tb_cpu_run_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, stop, step, bp_en;
  logic [10:0] pc, bp_addr;
  logic [6:0]  opcode;
  logic        commit_en, busy, commit_en4, busy4;
  logic [1:0]  state, halt_cause, state4, halt_cause4;
  logic [31:0] retired;
  logic [3:0]  retired4;

  int n_cmp = 0;
  int n_err = 0;

  logic [6:0] legal_ops [7] = '{7'b0110011, 7'b0010011, 7'b0100011, 7'b0000011,
                                7'b1100011, 7'b1101111, 7'b1100111};

  always #5 clk = ~clk;

  cpu_run_ctrl #(.PC_W(11), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .step(step),
    .pc(pc), .opcode(opcode), .bp_en(bp_en), .bp_addr(bp_addr),
    .commit_en(commit_en), .state(state), .halt_cause(halt_cause),
    .retired(retired), .busy(busy)
  );

  cpu_run_ctrl #(.PC_W(11), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .step(step),
    .pc(pc), .opcode(opcode), .bp_en(bp_en), .bp_addr(bp_addr),
    .commit_en(commit_en4), .state(state4), .halt_cause(halt_cause4),
    .retired(retired4), .busy(busy4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 0; stop = 0; step = 0; bp_en = 0;
    pc = '0; bp_addr = '0; opcode = legal_ops[0];
    #2;
    n_cmp++; if (state !== 2'd0) begin n_err++; $display("FAIL reset_state got %0d want 0", state); end
    n_cmp++; if (halt_cause !== 2'd0) begin n_err++; $display("FAIL reset_cause got %0d want 0", halt_cause); end
    n_cmp++; if (retired !== 32'd0) begin n_err++; $display("FAIL reset_retired got %0d want 0", retired); end
    n_cmp++; if (commit_en !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL reset_commit_busy got %b%b want 00", commit_en, busy); end
    tick();
    rst = 1'b0;
    tick();
    n_cmp++; if (state !== 2'd0) begin n_err++; $display("FAIL idle_hold got %0d want 0", state); end
  endtask

  task automatic test_illegal();
    start = 1'b1;
    #1;
    n_cmp++; if (commit_en !== 1'b0) begin n_err++; $display("FAIL idle_commit got %b want 0", commit_en); end
    tick();
    start = 1'b0;
    n_cmp++; if (state !== 2'd1 || busy !== 1'b1) begin n_err++; $display("FAIL run_entry got state %0d busy %b want 1 1", state, busy); end
    for (int i = 0; i < 5; i++) begin
      pc = 11'(4 * i); opcode = legal_ops[i % 7];
      #1;
      n_cmp++; if (commit_en !== 1'b1) begin n_err++; $display("FAIL run_commit_%0d got %b want 1", i, commit_en); end
      tick();
    end
    pc = 11'h014; opcode = 7'b0000000;
    #1;
    n_cmp++; if (commit_en !== 1'b0) begin n_err++; $display("FAIL illegal_commit got %b want 0", commit_en); end
    tick();
    n_cmp++; if (state !== 2'd3 || halt_cause !== 2'd1) begin n_err++; $display("FAIL illegal_halt got state %0d cause %0d want 3 1", state, halt_cause); end
    n_cmp++; if (retired !== 32'd5) begin n_err++; $display("FAIL illegal_retired got %0d want 5", retired); end
  endtask

  task automatic test_breakpoint();
    bp_en = 1'b1; bp_addr = 11'h010; opcode = legal_ops[1];
    pc = 11'h008; start = 1'b1;
    tick();
    start = 1'b0;
    n_cmp++; if (state !== 2'd1 || halt_cause !== 2'd0) begin n_err++; $display("FAIL bp_resume got state %0d cause %0d want 1 0", state, halt_cause); end
    tick();
    pc = 11'h00c;
    tick();
    pc = 11'h010;
    #1;
    n_cmp++; if (commit_en !== 1'b0) begin n_err++; $display("FAIL bp_block got %b want 0", commit_en); end
    tick();
    n_cmp++; if (state !== 2'd3 || halt_cause !== 2'd3) begin n_err++; $display("FAIL bp_halt got state %0d cause %0d want 3 3", state, halt_cause); end
    n_cmp++; if (retired !== 32'd7) begin n_err++; $display("FAIL bp_retired got %0d want 7", retired); end
    start = 1'b1;
    tick();
    start = 1'b0;
    #1;
    n_cmp++; if (commit_en !== 1'b1) begin n_err++; $display("FAIL bp_skip_commit got %b want 1", commit_en); end
    tick();
    pc = 11'h014;
    #1;
    n_cmp++; if (commit_en !== 1'b1 || state !== 2'd1) begin n_err++; $display("FAIL bp_continue got commit %b state %0d want 1 1", commit_en, state); end
    tick();
    pc = 11'h010;
    #1;
    n_cmp++; if (commit_en !== 1'b0) begin n_err++; $display("FAIL bp_rearm got %b want 0", commit_en); end
    tick();
    n_cmp++; if (state !== 2'd3 || halt_cause !== 2'd3 || retired !== 32'd9) begin n_err++; $display("FAIL bp_rehalt got state %0d cause %0d retired %0d want 3 3 9", state, halt_cause, retired); end
  endtask

  task automatic test_step();
    pc = 11'h020; opcode = legal_ops[2];
    for (int i = 0; i < 3; i++) begin
      step = 1'b1;
      #1;
      n_cmp++; if (commit_en !== 1'b0) begin n_err++; $display("FAIL step_pre_%0d got %b want 0", i, commit_en); end
      tick();
      step = 1'b0;
      n_cmp++; if (state !== 2'd2 || busy !== 1'b1 || commit_en !== 1'b1) begin n_err++; $display("FAIL step_exec_%0d got state %0d busy %b commit %b want 2 1 1", i, state, busy, commit_en); end
      tick();
      n_cmp++; if (state !== 2'd3 || halt_cause !== 2'd0) begin n_err++; $display("FAIL step_halt_%0d got state %0d cause %0d want 3 0", i, state, halt_cause); end
      tick();
      n_cmp++; if (state !== 2'd3 || commit_en !== 1'b0) begin n_err++; $display("FAIL step_idle_%0d got state %0d commit %b want 3 0", i, state, commit_en); end
    end
    n_cmp++; if (retired !== 32'd12) begin n_err++; $display("FAIL step_retired got %0d want 12", retired); end
  endtask

  task automatic test_stop_bp();
    bp_addr = 11'h030; pc = 11'h02c; opcode = legal_ops[3]; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    pc = 11'h030; stop = 1'b1;
    #1;
    n_cmp++; if (commit_en !== 1'b0) begin n_err++; $display("FAIL stop_bp_commit got %b want 0", commit_en); end
    tick();
    stop = 1'b0;
    n_cmp++; if (state !== 2'd3 || halt_cause !== 2'd2) begin n_err++; $display("FAIL stop_bp_halt got state %0d cause %0d want 3 2", state, halt_cause); end
    n_cmp++; if (retired !== 32'd13) begin n_err++; $display("FAIL stop_bp_retired got %0d want 13", retired); end
    bp_en = 1'b0;
  endtask

  task automatic test_async_reset();
    pc = 11'h040; opcode = legal_ops[4]; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    #2;
    rst = 1'b1;
    #1;
    n_cmp++; if (state !== 2'd0 || retired !== 32'd0 || retired4 !== 4'd0) begin n_err++; $display("FAIL async_rst got state %0d retired %0d/%0d want 0 0/0", state, retired, retired4); end
    n_cmp++; if (commit_en !== 1'b0 || busy !== 1'b0 || halt_cause !== 2'd0) begin n_err++; $display("FAIL async_rst_out got commit %b busy %b cause %0d want 0 0 0", commit_en, busy, halt_cause); end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_start_step();
    start = 1'b1; step = 1'b1;
    tick();
    start = 1'b0; step = 1'b0;
    n_cmp++; if (state !== 2'd1) begin n_err++; $display("FAIL start_over_step got %0d want 1", state); end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    n_cmp++; if (state !== 2'd3 || halt_cause !== 2'd2) begin n_err++; $display("FAIL stop_run got state %0d cause %0d want 3 2", state, halt_cause); end
  endtask

  task automatic test_wrap();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 17; i++) begin
      pc = 11'(4 * i); opcode = legal_ops[i % 7];
      tick();
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    n_cmp++; if (retired4 !== 4'd1) begin n_err++; $display("FAIL wrap_retired4 got %0d want 1", retired4); end
    n_cmp++; if (retired !== 32'd17) begin n_err++; $display("FAIL wrap_retired32 got %0d want 17", retired); end
  endtask

  initial begin
    test_reset();
    test_illegal();
    test_breakpoint();
    test_step();
    test_stop_bp();
    test_async_reset();
    test_start_step();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
Run/halt sequencer for the single-cycle RV32 core. It replaces the free-running "valid opcode" PC enable with a controlled commit enable. The enable gates the PC latch, the register-file write and the data-RAM write. The block supports start, stop, single-step, a one-address PC breakpoint, halt-on-illegal-opcode, and a retired-instruction counter. It sits beside control_unit and is clocked by the same core clock as PC and reg_file.

Parameters:
PC_W, 11, width of PC and breakpoint address
CNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  core clock (PLL outclk_0 domain); all state updates on rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  level sampled each cycle; begin free-running execution
stop  in  1  level sampled each cycle; request halt
step  in  1  level sampled each cycle; execute exactly one instruction
pc  in  PC_W  current PC register value
opcode  in  7  instr[6:0] of current instruction
bp_en  in  1  breakpoint enable
bp_addr  in  PC_W  breakpoint PC
commit_en  out  1  combinational; 1 = current instruction commits this cycle (PC, RegWrite, MemWrite gated by it)
state  out  2  0 IDLE, 1 RUN, 2 STEP, 3 HALT
halt_cause  out  2  0 none, 1 illegal opcode, 2 stop, 3 breakpoint
retired  out  CNT_W  count of committed instructions
busy  out  1  state is RUN or STEP

Behaviour:
- Reset (async, any time, including mid-RUN): state=IDLE, halt_cause=0, retired=0, skip_bp=0. commit_en=0 and busy=0 while rst is high.
- Legal opcodes: 0110011, 0010011, 0100011, 0000011, 1100011, 1101111, 1100111. legal = opcode is in this set.
- bp_hit = bp_en & (pc==bp_addr) & ~skip_bp.
- commit_en (combinational, same cycle):
  - In RUN: ~stop & legal & ~bp_hit.
  - In STEP: ~stop & legal. Breakpoints are ignored in STEP.
  - In IDLE and HALT: 0.
- IDLE or HALT:
  - start=1: go to RUN. start wins over step when both are high.
  - else step=1: go to STEP.
  - halt_cause is cleared to 0 on leaving HALT.
  - stop is ignored in IDLE and HALT.
  - Leaving HALT with halt_cause=3 sets skip_bp=1, so resume/step from a breakpoint executes that instruction.
- RUN, priority stop > illegal > breakpoint:
  - stop=1: go to HALT, cause 2.
  - else ~legal: go to HALT, cause 1.
  - else bp_hit: go to HALT, cause 3.
  - else stay in RUN.
  - start and step are ignored in RUN.
- STEP (one cycle only):
  - stop=1: go to HALT, cause 2.
  - else ~legal: go to HALT, cause 1.
  - else go to HALT, cause 0, after committing one instruction.
- skip_bp clears on the first edge where commit_en=1.
- retired increments by 1 on every edge where commit_en=1. It wraps modulo 2^CNT_W with no saturation and is cleared only by rst.
- The PC value is not modified by this block. A halted instruction is re-presented unchanged on resume.
- Latency:
  - start/step sampled at edge N puts state=RUN/STEP after edge N. The first commit occurs in cycle N+1.
  - stop asserted in cycle N suppresses commit in cycle N (zero latency).

Test Plan:
- Reset, then start pulse with 5 legal instructions followed by opcode 0000000: commit_en high for 5 cycles, then HALT with halt_cause=1 and retired=5. PC holds at the illegal address.
- RUN with bp_en=1, bp_addr=0x010: HALT with cause 3 and commit_en=0 at pc=0x010. Next start commits 0x010 (skip_bp), continues to 0x014, and does not re-halt at 0x010 within that pass.
- From HALT, three separate one-cycle step pulses: exactly one commit per pulse, state sequence STEP then HALT each time, retired +3, halt_cause=0.
- RUN with stop asserted in the same cycle as a legal instruction at a breakpoint PC: commit_en=0 and halt_cause=2 (stop beats breakpoint).
- start and step both high in IDLE: state goes to RUN, not STEP.
- rst asserted asynchronously mid-RUN between edges: state=IDLE, retired=0 and commit_en=0 immediately, before the next clk edge.
- CNT_W=4 run of 17 commits: retired wraps to 1.
